// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

   localparam int unsigned CLK_HZ      = 100_000_000;
   localparam logic        MODE_SQUARE = 1'b0;
   localparam logic        MODE_PULSE  = 1'b1;

   // Terminal count that yields a square wave of f Hz from CLK_HZ.
   function automatic int unsigned half_for_hz(input int unsigned f);
      return (CLK_HZ / (2 * f)) - 1;
   endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, live and shadow config, pending flag, output regs.
module div_channel
   import clk_div_pkg::*;
#(
   parameter int unsigned      CNT_W    = 27,
   parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(4_999_999)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_half,
   input  logic             i_mode,
   input  logic             i_en,
   input  logic             i_sync,
   output logic             o_pending,
   output logic             o_div,
   output logic             o_tick
);

   logic [CNT_W-1:0] r_ctr, r_half, r_sh_half;
   logic             r_mode, r_en, r_sh_mode, r_sh_en;
   logic             r_pending, r_div, r_tick;

   logic [CNT_W-1:0] w_ctr_nxt, w_half_nxt, w_sh_half_nxt;
   logic             w_mode_nxt, w_en_nxt, w_sh_mode_nxt, w_sh_en_nxt;
   logic             w_pending_nxt, w_div_nxt, w_tick_nxt;
   logic             w_term, w_apply;

   // Next-state: count/terminal/sync behaviour, then pending apply, then shadow write.
   always_comb begin
      w_term        = r_en && (r_ctr == r_half);
      w_apply       = r_pending && (!r_en || i_sync || w_term);
      w_ctr_nxt     = r_ctr;
      w_div_nxt     = r_div;
      w_tick_nxt    = 1'b0;
      w_half_nxt    = r_half;
      w_mode_nxt    = r_mode;
      w_en_nxt      = r_en;
      w_sh_half_nxt = r_sh_half;
      w_sh_mode_nxt = r_sh_mode;
      w_sh_en_nxt   = r_sh_en;
      w_pending_nxt = r_pending;

      if (!r_en) begin
         w_ctr_nxt = '0;
         w_div_nxt = 1'b0;
      end else if (i_sync) begin
         // sync outranks a coincident terminal: no tick, no toggle
         w_ctr_nxt = '0;
         w_div_nxt = 1'b0;
      end else if (w_term) begin
         w_ctr_nxt  = '0;
         w_tick_nxt = 1'b1;
         w_div_nxt  = (r_mode == MODE_PULSE) ? 1'b1 : ~r_div;
      end else begin
         w_ctr_nxt = r_ctr + CNT_W'(1);
         if (r_mode == MODE_PULSE) begin
            w_div_nxt = 1'b0;
         end
      end

      if (w_apply) begin
         w_half_nxt    = r_sh_half;
         w_mode_nxt    = r_sh_mode;
         w_en_nxt      = r_sh_en;
         w_pending_nxt = 1'b0;
         w_ctr_nxt     = '0;
         if (!r_sh_en) begin
            w_div_nxt  = 1'b0;
            w_tick_nxt = 1'b0;
         end
      end

      // Only accepted writes arrive here, so pending is clear and w_apply is 0.
      if (i_wr) begin
         w_sh_half_nxt = i_half;
         w_sh_mode_nxt = i_mode;
         w_sh_en_nxt   = i_en;
         w_pending_nxt = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctr     <= '0;
         r_half    <= RST_HALF;
         r_mode    <= MODE_SQUARE;
         r_en      <= 1'b1;
         r_sh_half <= RST_HALF;
         r_sh_mode <= MODE_SQUARE;
         r_sh_en   <= 1'b1;
         r_pending <= 1'b0;
         r_div     <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_ctr     <= w_ctr_nxt;
         r_half    <= w_half_nxt;
         r_mode    <= w_mode_nxt;
         r_en      <= w_en_nxt;
         r_sh_half <= w_sh_half_nxt;
         r_sh_mode <= w_sh_mode_nxt;
         r_sh_en   <= w_sh_en_nxt;
         r_pending <= w_pending_nxt;
         r_div     <= w_div_nxt;
         r_tick    <= w_tick_nxt;
      end
   end

   assign o_pending = r_pending;
   assign o_div     = r_div;
   assign o_tick    = r_tick;

endmodule

// File: rtl/multi_clk_div_gen.sv
// Multi-channel programmable divider: channel decode, ready mux and sync fan-out.
module multi_clk_div_gen
   import clk_div_pkg::*;
#(
   parameter  int unsigned NUM_CH       = 4,
   parameter  int unsigned CNT_W        = 27,
   parameter  int unsigned DEFAULT_HALF = half_for_hz(10),
   localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_half,
   input  logic              cfg_mode,
   input  logic              cfg_en,
   output logic              cfg_ready,
   input  logic              sync_i,
   output logic [NUM_CH-1:0] div_out,
   output logic [NUM_CH-1:0] tick_out
);

   logic [NUM_CH-1:0] w_pending;
   logic [NUM_CH-1:0] w_wr;

   // Ready for the addressed channel; out-of-range channels are never ready.
   always_comb begin
      cfg_ready = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = !w_pending[i];
         end
      end
   end

   // Per-channel write decode and divider instances.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_wr[g] = cfg_we && cfg_ready && (cfg_ch == CH_W'(g));

      div_channel #(
         .CNT_W    (CNT_W),
         .RST_HALF (CNT_W'(DEFAULT_HALF))
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_wr      (w_wr[g]),
         .i_half    (cfg_half),
         .i_mode    (cfg_mode),
         .i_en      (cfg_en),
         .i_sync    (sync_i),
         .o_pending (w_pending[g]),
         .o_div     (div_out[g]),
         .o_tick    (tick_out[g])
      );
   end

endmodule
